// File: rtl/modulo_fsm_estados_sistema_pkg.sv
// Shared definitions for the system-state controller: state codes and default sizing.
package modulo_fsm_estados_sistema_pkg;

  // State codes; the numeric values are the sta[1:0] code seen by the matrix selector.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CONFIG = 2'b01,
    ST_RUN    = 2'b10,
    ST_ALARM  = 2'b11
  } estado_t;

  // Default config-mode inactivity timeout (clk cycles) and the counter width that holds it.
  localparam int TIMEOUT_CYCLES_DEF = 50_000_000;
  localparam int CNT_W_DEF          = 26;

  // Saturating increment: stops at 'last' so the timer can never wrap.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] last);
    if (value >= last) begin
      return last;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/modulo_fsm_estados_sistema_sincroniza_borda.sv
// Two-flop synchroniser for one asynchronous input followed by a rising-edge detector.
// d_sync is the synchronised level, d_rise a one-cycle pulse on each 0->1 of that level.
module modulo_sincroniza_borda (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_sync,
  output logic d_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw input through the metastability flop, the sync flop and the edge-history flop.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Register the synchroniser chain; reset clears it so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign d_sync = sync_q;
  assign d_rise = sync_q & ~prev_q;

endmodule

// File: rtl/modulo_fsm_estados_sistema.sv
// System-state controller: owns the 2-bit state code sta that drives the matrix selector.
// Synchronises the buttons and the alarm sensor, applies the transition priorities,
// runs the CONFIG inactivity timeout and emits a one-cycle pulse after every state change.
module modulo_fsm_estados_sistema
  import modulo_fsm_estados_sistema_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_cfg,
  input  logic       btn_ack,
  input  logic       alarm_in,
  output logic [1:0] sta,
  output logic       sta_chg
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic start_rise, cfg_rise, ack_rise, alarm_lvl;
  logic start_sync_unused, cfg_sync_unused, ack_sync_unused, alarm_rise_unused;

  estado_t          sta_q, sta_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             chg_pend_q, chg_pend_d;
  logic             sta_chg_q, sta_chg_d;
  logic             any_edge;
  logic             timeout_hit;

  modulo_sincroniza_borda u_sync_start (
    .clk    (clk),
    .rst    (rst),
    .d_in   (btn_start),
    .d_sync (start_sync_unused),
    .d_rise (start_rise)
  );

  modulo_sincroniza_borda u_sync_cfg (
    .clk    (clk),
    .rst    (rst),
    .d_in   (btn_cfg),
    .d_sync (cfg_sync_unused),
    .d_rise (cfg_rise)
  );

  modulo_sincroniza_borda u_sync_ack (
    .clk    (clk),
    .rst    (rst),
    .d_in   (btn_ack),
    .d_sync (ack_sync_unused),
    .d_rise (ack_rise)
  );

  modulo_sincroniza_borda u_sync_alarm (
    .clk    (clk),
    .rst    (rst),
    .d_in   (alarm_in),
    .d_sync (alarm_lvl),
    .d_rise (alarm_rise_unused)
  );

  // Next state, timeout timer and change pipeline; alarm overrides every other input.
  always_comb begin
    any_edge    = start_rise | cfg_rise | ack_rise;
    timeout_hit = (timer_q == TIMER_LAST) && !any_edge;

    sta_d = sta_q;
    if (alarm_lvl) begin
      sta_d = ST_ALARM;
    end else begin
      case (sta_q)
        ST_IDLE: begin
          if (start_rise)    sta_d = ST_RUN;
          else if (cfg_rise) sta_d = ST_CONFIG;
        end
        ST_CONFIG: begin
          if (start_rise)       sta_d = ST_RUN;
          else if (cfg_rise)    sta_d = ST_IDLE;
          else if (timeout_hit) sta_d = ST_IDLE;
        end
        ST_RUN: begin
          if (start_rise) sta_d = ST_IDLE;
        end
        ST_ALARM: begin
          if (ack_rise) sta_d = ST_IDLE;
        end
        default: sta_d = ST_IDLE;
      endcase
    end

    timer_d = '0;
    if ((sta_q == ST_CONFIG) && (sta_d == ST_CONFIG) && !any_edge) begin
      timer_d = CNT_W'(sat_inc(32'(timer_q), 32'(TIMER_LAST)));
    end

    chg_pend_d = (sta_d != sta_q);
    sta_chg_d  = chg_pend_q;
  end

  // State register with registered outputs; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sta_q      <= ST_IDLE;
      timer_q    <= '0;
      chg_pend_q <= 1'b0;
      sta_chg_q  <= 1'b0;
    end else begin
      sta_q      <= sta_d;
      timer_q    <= timer_d;
      chg_pend_q <= chg_pend_d;
      sta_chg_q  <= sta_chg_d;
    end
  end

  assign sta     = sta_q;
  assign sta_chg = sta_chg_q;

endmodule

// File: tb/tb_modulo_fsm_estados_sistema.sv
// Self-checking bench for the system-state controller with a short timeout (8 cycles).
// A cycle-level reference model derived from the behavioural rules runs beside the DUT.
module tb_modulo_fsm_estados_sistema;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_cfg = 1'b0;
  logic       btn_ack = 1'b0;
  logic       alarm_in = 1'b0;
  logic [1:0] sta;
  logic       sta_chg;

  int checks = 0;
  int failures = 0;

  modulo_fsm_estados_sistema #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_cfg   (btn_cfg),
    .btn_ack   (btn_ack),
    .alarm_in  (alarm_in),
    .sta       (sta),
    .sta_chg   (sta_chg)
  );

  always #5 clk = ~clk;

  // Reference model: each raw input is seen by the state logic two edges after it was sampled;
  // a press counts once when that delayed level goes 0->1. The CONFIG timeout fires TO edges
  // after the last CONFIG entry or button press. sta_chg reports the change one edge late.
  logic [2:0] h_st, h_cf, h_ak, h_al;
  logic [1:0] m_sta, m_sta_old, nxt;
  logic       m_chg;
  int         cyc = 0;
  int         last_act = 0;
  logic       st_e, cf_e, ak_e, al_l, any_e;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      h_st = '0; h_cf = '0; h_ak = '0; h_al = '0;
      m_sta = 2'd0; m_sta_old = 2'd0; m_chg = 1'b0;
      last_act = cyc;
    end else begin
      al_l  = h_al[1];
      st_e  = h_st[1] & ~h_st[2];
      cf_e  = h_cf[1] & ~h_cf[2];
      ak_e  = h_ak[1] & ~h_ak[2];
      any_e = st_e | cf_e | ak_e;
      nxt = m_sta;
      if (al_l) nxt = 2'd3;
      else begin
        case (m_sta)
          2'd0: if (st_e) nxt = 2'd2; else if (cf_e) nxt = 2'd1;
          2'd1: if (st_e) nxt = 2'd2; else if (cf_e) nxt = 2'd0;
                else if (!any_e && (cyc - last_act) >= TO) nxt = 2'd0;
          2'd2: if (st_e) nxt = 2'd0;
          default: if (ak_e) nxt = 2'd0;
        endcase
      end
      if (nxt == 2'd1 && (m_sta != 2'd1 || any_e)) last_act = cyc;
      m_chg = (m_sta != m_sta_old);
      m_sta_old = m_sta;
      m_sta = nxt;
      h_st = {h_st[1:0], btn_start};
      h_cf = {h_cf[1:0], btn_cfg};
      h_ak = {h_ak[1:0], btn_ack};
      h_al = {h_al[1:0], alarm_in};
    end
  end

  // Clean reset with all inputs low; returns just after a falling clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn_start = 1'b0; btn_cfg = 1'b0; btn_ack = 1'b0; alarm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_start = 1'($urandom); btn_cfg = 1'($urandom);
      btn_ack = 1'($urandom); alarm_in = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    btn_start = 1'($urandom); btn_cfg = 1'($urandom);
    btn_ack = 1'($urandom); alarm_in = 1'($urandom);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (sta !== 2'b00) begin
        failures++; $display("[TB] FAIL reset_sta: cycle %0d sta=%b expected 00", i, sta);
      end
      checks++;
      if (sta_chg !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_chg: cycle %0d sta_chg=%b expected 0", i, sta_chg);
      end
    end
  endtask

  task automatic test_start_latency();
    logic [1:0] exp_sta;
    logic       exp_chg;
    do_reset();
    btn_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_sta = (i >= 3) ? 2'b10 : 2'b00;
      exp_chg = (i == 4);
      checks++;
      if (sta !== exp_sta) begin
        failures++; $display("[TB] FAIL start_sta: cycle %0d sta=%b expected %b", i, sta, exp_sta);
      end
      checks++;
      if (sta_chg !== exp_chg) begin
        failures++; $display("[TB] FAIL start_chg: cycle %0d sta_chg=%b expected %b", i, sta_chg, exp_chg);
      end
    end
    btn_start = 1'b0;
  endtask

  task automatic test_timeout();
    logic [1:0] exp_sta;
    // Plain timeout: entry at cycle 3, return to IDLE 8 cycles later.
    do_reset();
    for (int i = 0; i <= 13; i++) begin
      if (i > 0) begin
        @(negedge clk);
        exp_sta = (i >= 3 && i < 11) ? 2'b01 : 2'b00;
        checks++;
        if (sta !== exp_sta) begin
          failures++; $display("[TB] FAIL timeout_sta: cycle %0d sta=%b expected %b", i, sta, exp_sta);
        end
        checks++;
        if (sta_chg !== m_chg) begin
          failures++; $display("[TB] FAIL timeout_chg: cycle %0d sta_chg=%b expected %b", i, sta_chg, m_chg);
        end
      end
      btn_cfg = (i == 0);
    end
    // A button press 5 cycles into CONFIG restarts the inactivity timer.
    do_reset();
    for (int i = 0; i <= 18; i++) begin
      if (i > 0) begin
        @(negedge clk);
        exp_sta = (i >= 3 && i < 16) ? 2'b01 : 2'b00;
        checks++;
        if (sta !== exp_sta) begin
          failures++; $display("[TB] FAIL restart_sta: cycle %0d sta=%b expected %b", i, sta, exp_sta);
        end
      end
      btn_cfg = (i == 0);
      btn_ack = (i == 5);
    end
  endtask

  task automatic test_alarm();
    logic [1:0] exp_sta;
    do_reset();
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (i < 3) exp_sta = 2'b00;
        else if (i < 8) exp_sta = 2'b10;
        else if (i < 21) exp_sta = 2'b11;
        else exp_sta = 2'b00;
        checks++;
        if (sta !== exp_sta) begin
          failures++; $display("[TB] FAIL alarm_sta: cycle %0d sta=%b expected %b", i, sta, exp_sta);
        end
        checks++;
        if (sta_chg !== m_chg) begin
          failures++; $display("[TB] FAIL alarm_chg: cycle %0d sta_chg=%b expected %b", i, sta_chg, m_chg);
        end
      end
      btn_start = (i == 0);
      btn_ack   = (i == 10) || (i == 18);
      if (i == 5)  alarm_in = 1'b1;
      if (i == 14) alarm_in = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    // Start and config in the same cycle from IDLE: start wins.
    do_reset();
    btn_start = 1'b1; btn_cfg = 1'b1;
    @(negedge clk);
    btn_start = 1'b0; btn_cfg = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sta !== 2'b10) begin
      failures++; $display("[TB] FAIL simul_start_cfg: sta=%b expected 10", sta);
    end
    // Alarm and start in the same cycle from IDLE: alarm wins.
    do_reset();
    btn_start = 1'b1; alarm_in = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sta !== 2'b11) begin
      failures++; $display("[TB] FAIL simul_alarm_start: sta=%b expected 11", sta);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sta !== 2'b11 || sta_chg !== 1'b0) begin
      failures++; $display("[TB] FAIL alarm_hold: sta=%b sta_chg=%b expected 11/0", sta, sta_chg);
    end
    alarm_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_sta;
    do_reset();
    for (int i = 0; i <= 23; i++) begin
      if (i > 0) begin
        @(negedge clk);
        exp_sta = ((i >= 3 && i < 9) || (i >= 13 && i < 21)) ? 2'b01 : 2'b00;
        checks++;
        if (sta !== exp_sta) begin
          failures++; $display("[TB] FAIL midreset_sta: cycle %0d sta=%b expected %b", i, sta, exp_sta);
        end
        checks++;
        if (sta_chg !== m_chg) begin
          failures++; $display("[TB] FAIL midreset_chg: cycle %0d sta_chg=%b expected %b", i, sta_chg, m_chg);
        end
      end
      btn_cfg = (i == 0) || (i == 10);
      rst     = (i == 8);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (sta !== m_sta) begin
        failures++; $display("[TB] FAIL random_sta: step %0d sta=%b expected %b", i, sta, m_sta);
      end
      checks++;
      if (sta_chg !== m_chg) begin
        failures++; $display("[TB] FAIL random_chg: step %0d sta_chg=%b expected %b", i, sta_chg, m_chg);
      end
      btn_start = ($urandom_range(0, 19) == 0);
      btn_cfg   = ($urandom_range(0, 11) == 0) ? ~btn_cfg : btn_cfg;
      btn_ack   = ($urandom_range(0, 14) == 0);
      if (!alarm_in && $urandom_range(0, 59) == 0) alarm_in = 1'b1;
      else if (alarm_in && $urandom_range(0, 7) == 0) alarm_in = 1'b0;
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_timeout();
    test_alarm();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
